// File: rtl/fifo_pgk.sv
// Shared FIFO-side definitions: arbiter state encoding.
package fifo_pgk;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_BURST
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-side bundle for fifo_wr_arbiter.
// master: the arbiter; slave: the surrounding producers and FIFO.
interface fifo_wr_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic                    fifo_full;
    logic                    fifo_push;
    logic [DATA_W-1:0]       fifo_data;
    logic [IDX_W-1:0]        grant_id;
    logic                    busy;

    modport master (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_push, fifo_data, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_push, fifo_data, grant_id, busy
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin pick: first set request scanning upward from last_owner+1, with wrap.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_owner,
    output logic [IDX_W-1:0] pick,
    output logic             any
);

    // Scan N_REQ positions starting just after the previous owner; first hit wins.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            if (!any && req[(32'(last_owner) + k) % N_REQ]) begin
                any  = 1'b1;
                pick = IDX_W'((32'(last_owner) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter feeding a FIFO through a one-entry output register.
module fifo_wr_arbiter
    import fifo_pgk::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_MAX = 4
) (
    input logic               wr_clk,
    input logic               wr_rst,
    fifo_wr_arbiter_if.master bus
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_owner_q, last_owner_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               push_q, push_d;
    logic [DATA_W-1:0]  data_q, data_d;

    logic [IDX_W-1:0]   pick;
    logic               any_valid;
    logic               slot_free;
    logic               xfer;
    logic [N_REQ-1:0]   ready;
    logic               owner_valid;
    logic               owner_last;
    logic [DATA_W-1:0]  owner_word;
    logic [CNT_W-1:0]   beat_next;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req        (bus.req_valid),
        .last_owner (last_owner_q),
        .pick       (pick),
        .any        (any_valid)
    );

    // The output register can take a new word unless it holds one the FIFO is refusing.
    assign slot_free = !push_q || !bus.fifo_full;
    assign beat_next = beat_cnt_q + CNT_W'(1);

    // Select the current owner's valid/last/data.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_word  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                owner_valid = bus.req_valid[i];
                owner_last  = bus.req_last[i];
                owner_word  = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Arbitration FSM: grant, count beats, and release on last, cap or give-up.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        ready        = '0;
        xfer         = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (any_valid) begin
                    owner_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = ARB_BURST;
                end
            end
            ARB_BURST: begin
                ready[owner_q] = slot_free;
                xfer           = slot_free && owner_valid;
                if (xfer) begin
                    beat_cnt_d = beat_next;
                    if (owner_last || beat_next == CNT_W'(BURST_MAX)) begin
                        state_d      = ARB_IDLE;
                        last_owner_d = owner_q;
                    end
                end else if (slot_free && !owner_valid) begin
                    state_d      = ARB_IDLE;
                    last_owner_d = owner_q;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Output register: load on transfer, drain once the FIFO took the word, else hold.
    always_comb begin
        push_d = push_q;
        data_d = data_q;
        if (xfer) begin
            push_d = 1'b1;
            data_d = owner_word;
        end else if (slot_free) begin
            push_d = 1'b0;
        end
    end

    // State registers; last_owner resets to N_REQ-1 so requester 0 wins first.
    always_ff @(posedge wr_clk) begin
        if (!wr_rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(N_REQ - 1);
            beat_cnt_q   <= '0;
            push_q       <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
            push_q       <= push_d;
            data_q       <= data_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.fifo_push = push_q;
    assign bus.fifo_data = data_q;
    assign bus.grant_id  = owner_q;
    assign bus.busy      = (state_q == ARB_BURST) || push_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random self-checking bench for fifo_wr_arbiter.
module tb_fifo_wr_arbiter;

    localparam int unsigned N_REQ     = 4;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BURST_MAX = 4;

    logic wr_clk = 1'b0;
    logic wr_rst = 1'b0;

    always #5 wr_clk = ~wr_clk;

    fifo_wr_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

    fifo_wr_arbiter #(
        .N_REQ     (N_REQ),
        .DATA_W    (DATA_W),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .wr_clk (wr_clk),
        .wr_rst (wr_rst),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Requester source queues hold {last, data}; exp_q is the scoreboard per requester.
    logic [8:0]       src_q [N_REQ][$];
    logic [7:0]       exp_q [N_REQ][$];
    logic [7:0]       wlog [$];
    int               wcyc [$];
    logic [N_REQ-1:0] en = '1;
    logic [N_REQ-1:0] took = '0;
    logic [5:0]       seq [N_REQ];
    bit               sb_en = 1'b0;
    bit               rand_mode = 1'b0;
    int               cyc = 0;
    bit               held_v = 1'b0;
    logic [7:0]       held_d = '0;
    int               bc = 0;
    bit               need_gap = 1'b0;
    int               n_xfer = 0;
    int               n_wr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Edge monitor: FIFO writes, requester transfers, hold-while-full and burst length.
    always @(posedge wr_clk) begin : mon
        int id;
        int bc_n;
        cyc <= cyc + 1;
        if (!wr_rst) begin
            took     <= '0;
            held_v   <= 1'b0;
            bc       <= 0;
            need_gap <= 1'b0;
        end else begin
            took <= bus.req_valid & bus.req_ready;
            check("ready_onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
            if (held_v) begin
                check("hold_push", 32'(bus.fifo_push), 32'd1);
                check("hold_data", 32'(bus.fifo_data), 32'(held_d));
            end
            held_v <= bus.fifo_push && bus.fifo_full;
            held_d <= bus.fifo_data;
            if (bus.fifo_push && !bus.fifo_full) begin
                wlog.push_back(bus.fifo_data);
                wcyc.push_back(cyc);
                if (sb_en) begin
                    n_wr++;
                    id = int'(bus.fifo_data[7:6]);
                    if (exp_q[id].size() == 0)
                        check("sb_spurious_write", 32'(exp_q[id].size()), 32'd1);
                    else
                        check("sb_order", 32'(bus.fifo_data), 32'(exp_q[id].pop_front()));
                end
            end
            if (|(bus.req_valid & bus.req_ready)) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (sb_en && bus.req_valid[i] && bus.req_ready[i]) begin
                        exp_q[i].push_back(bus.req_data[i*DATA_W +: DATA_W]);
                        n_xfer++;
                    end
                end
                check("burst_gap", 32'(need_gap), 32'd0);
                bc_n = bc + 1;
                check("burst_len", 32'(bc_n <= BURST_MAX), 32'd1);
                if (|(bus.req_valid & bus.req_ready & bus.req_last) || bc_n >= BURST_MAX) begin
                    need_gap <= 1'b1;
                    bc       <= 0;
                end else begin
                    bc <= bc_n;
                end
            end else if (bus.req_ready == '0) begin
                bc       <= 0;
                need_gap <= 1'b0;
            end
        end
    end

    task automatic drive_inputs();
        logic [N_REQ-1:0]        v;
        logic [N_REQ-1:0]        l;
        logic [N_REQ*DATA_W-1:0] d;
        logic [8:0]              w;
        v = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (en[i] && src_q[i].size() > 0) begin
                w = src_q[i][0];
                v[i] = 1'b1;
                l[i] = w[8];
                d[i*DATA_W +: DATA_W] = w[7:0];
            end
        end
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
    endtask

    task automatic cycle();
        @(posedge wr_clk);
        #1;
        for (int i = 0; i < N_REQ; i++)
            if (took[i] && src_q[i].size() > 0) src_q[i].delete(0);
        if (rand_mode) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (src_q[i].size() == 0 && $urandom_range(0, 2) == 0) begin
                    src_q[i].push_back({1'($urandom_range(0, 3) == 0), 2'(i), seq[i]});
                    seq[i] = seq[i] + 6'd1;
                end
                if ($urandom_range(0, 15) == 0) en[i] = ~en[i];
            end
            bus.fifo_full = ($urandom_range(0, 3) == 0);
        end
        drive_inputs();
    endtask

    task automatic do_reset();
        for (int i = 0; i < N_REQ; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
            seq[i] = '0;
        end
        en            = '1;
        sb_en         = 1'b0;
        rand_mode     = 1'b0;
        bus.fifo_full = 1'b0;
        drive_inputs();
        wr_rst = 1'b0;
        @(posedge wr_clk);
        #1;
        wr_rst = 1'b1;
        wlog.delete();
        wcyc.delete();
    endtask

    task automatic wait_writes(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (wlog.size() < n && k < budget) begin
            cycle();
            k++;
        end
        check(tag, 32'(wlog.size()), 32'(n));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_push"},  32'(bus.fifo_push), 32'd0);
        check({tag, "_data"},  32'(bus.fifo_data), 32'd0);
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
        check({tag, "_grant"}, 32'(bus.grant_id),  32'd0);
        check({tag, "_busy"},  32'(bus.busy),      32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int b;
        int sq;

        // Reset state
        do_reset();
        check_idle_outputs("rst");

        // Single requester r2: 0x10..0x13, last on 0x13
        for (int k = 0; k < 4; k++) src_q[2].push_back({1'(k == 3), 8'(8'h10 + k)});
        drive_inputs();
        cycle();
        check("t1_grant", 32'(bus.grant_id), 32'd2);
        check("t1_ready", 32'(bus.req_ready), 32'h4);
        check("t1_busy", 32'(bus.busy), 32'd1);
        check("t1_push0", 32'(bus.fifo_push), 32'd0);
        cycle();
        check("t1_push1", 32'(bus.fifo_push), 32'd1);
        check("t1_data1", 32'(bus.fifo_data), 32'h10);
        repeat (3) cycle();
        check("t1_data_last", 32'(bus.fifo_data), 32'h13);
        check("t1_busy_tail", 32'(bus.busy), 32'd1);
        check("t1_ready_idle", 32'(bus.req_ready), 32'd0);
        check("t1_grant_hold", 32'(bus.grant_id), 32'd2);
        cycle();
        check("t1_push_drop", 32'(bus.fifo_push), 32'd0);
        check("t1_busy_drop", 32'(bus.busy), 32'd0);
        check("t1_nwrites", 32'(wlog.size()), 32'd4);
        for (int k = 0; k < wlog.size() && k < 4; k++) begin
            check("t1_word", 32'(wlog[k]), 32'(8'h10 + k));
            check("t1_consec", 32'(wcyc[k] - wcyc[0]), 32'(k));
        end

        // Fairness: all four valid with 8 words each, no last
        do_reset();
        for (int i = 0; i < N_REQ; i++)
            for (int k = 0; k < 8; k++) src_q[i].push_back({1'b0, 2'(i), 6'(k)});
        drive_inputs();
        wait_writes(20, 80, "t2_nwrites");
        for (int k = 0; k < wlog.size() && k < 20; k++) begin
            b  = k / 4;
            sq = (b / 4) * 4 + (k % 4);
            check("t2_order", 32'(wlog[k]), 32'((b % 4) * 64 + sq));
            if (k > 0) check("t2_spacing", 32'(wcyc[k] - wcyc[k-1]), (k % 4 == 0) ? 32'd2 : 32'd1);
        end

        // Full stall with 0xA5 held in the output register
        do_reset();
        src_q[0].push_back({1'b0, 8'hA5});
        src_q[0].push_back({1'b1, 8'h5A});
        drive_inputs();
        cycle();
        cycle();
        check("t3_push_pre", 32'(bus.fifo_push), 32'd1);
        check("t3_data_pre", 32'(bus.fifo_data), 32'hA5);
        bus.fifo_full = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("t3_stall_push", 32'(bus.fifo_push), 32'd1);
            check("t3_stall_data", 32'(bus.fifo_data), 32'hA5);
            check("t3_stall_ready", 32'(bus.req_ready), 32'd0);
            cycle();
        end
        bus.fifo_full = 1'b0;
        #1;
        check("t3_ready_rise", 32'(bus.req_ready), 32'h1);
        check("t3_no_write_yet", 32'(wlog.size()), 32'd0);
        cycle();
        check("t3_next_data", 32'(bus.fifo_data), 32'h5A);
        repeat (3) cycle();
        check("t3_nwrites", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            check("t3_w0", 32'(wlog[0]), 32'hA5);
            check("t3_w1", 32'(wlog[1]), 32'h5A);
        end

        // Owner r1 gives up after 2 words while r3 waits
        do_reset();
        for (int k = 0; k < 4; k++) src_q[1].push_back({1'b0, 8'(8'h40 + k)});
        for (int k = 0; k < 3; k++) src_q[3].push_back({1'(k == 2), 8'(8'hC0 + k)});
        drive_inputs();
        cycle();
        check("t4_grant_r1", 32'(bus.grant_id), 32'd1);
        cycle();
        cycle();
        en[1] = 1'b0;
        drive_inputs();
        cycle();
        check("t4_idle_ready", 32'(bus.req_ready), 32'd0);
        check("t4_idle_grant", 32'(bus.grant_id), 32'd1);
        cycle();
        check("t4_grant_r3", 32'(bus.grant_id), 32'd3);
        check("t4_ready_r3", 32'(bus.req_ready), 32'h8);
        wait_writes(5, 20, "t4_nwrites");
        for (int k = 0; k < wlog.size() && k < 5; k++)
            check("t4_order", 32'(wlog[k]), (k < 2) ? 32'(8'h40 + k) : 32'(8'hC0 + k - 2));

        // Reset mid-burst with a word in the output register
        do_reset();
        for (int k = 0; k < 4; k++) src_q[2].push_back({1'b0, 8'(8'h80 + k)});
        drive_inputs();
        repeat (3) cycle();
        check("t5_push_pre", 32'(bus.fifo_push), 32'd1);
        wr_rst = 1'b0;
        src_q[0].push_back({1'b1, 8'h01});
        drive_inputs();
        cycle();
        wr_rst = 1'b1;
        #1;
        check_idle_outputs("t5_rst");
        cycle();
        check("t5_grant_r0", 32'(bus.grant_id), 32'd0);
        check("t5_ready_r0", 32'(bus.req_ready), 32'h1);

        // Random scoreboard run
        do_reset();
        n_xfer    = 0;
        n_wr      = 0;
        sb_en     = 1'b1;
        rand_mode = 1'b1;
        repeat (5000) cycle();
        rand_mode = 1'b0;
        for (int i = 0; i < N_REQ; i++) src_q[i].delete();
        en            = '0;
        bus.fifo_full = 1'b0;
        drive_inputs();
        repeat (20) cycle();
        for (int i = 0; i < N_REQ; i++) check("sb_drained", 32'(exp_q[i].size()), 32'd0);
        check("sb_wr_eq_xfer", 32'(n_wr), 32'(n_xfer));
        check("sb_activity", 32'(n_xfer > 500), 32'd1);
        sb_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
